game_controller: RTL and testbench
==================================

# game_controller

Top-level sequencer for the two-car game: owns the Start / Countdown / Play / Over state machine, gates the obstacle generator and collision detector, counts score, derives the obstacle speed level, and keeps a high score. It sits between the board controls (start, reset, on/off) and the game datapath (object generator, collision detector, score display). It replaces the ad-hoc reset ORing currently done at the game top.

## Interface
Parameters:
- CD_STEP_FRAMES, 60, frames per countdown digit; three digits, 3→2→1.
- OVER_HOLD_FRAMES, 120, minimum frames in OVER before a restart is accepted.
- SPEED_STEP_POINTS, 10, points per speed-level increment.
- MAX_LEVEL, 7, saturation value of speed_level.
- SCORE_MAX, 9999, score saturation value; fits the 4-digit display.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per VGA frame.
- on_off  in  1  level; low forces IDLE.
- start_game  in  1  level, debounced, CLK-synchronous; acts on rising edge.
- reset_game  in  1  level, debounced, CLK-synchronous; acts on rising edge.
- end_game  in  1  collision/miss from collision detector; level, sampled each cycle.
- score_pulse  in  1  one-cycle point-scored pulse.
- state  out  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER.
- obj_run  out  1  obstacle generator enable.
- obj_rst  out  1  obstacle generator / collision detector reset.
- score_clr  out  1  one-cycle pulse on entry to COUNTDOWN.
- countdown_digit  out  2  3, 2, 1 in COUNTDOWN, else 0.
- speed_level  out  3  obstacle speed index, 0..MAX_LEVEL.
- score  out  14  current score, binary.
- high_score  out  14  best score since RST.

## Operation
- Edge detect: register start_game and reset_game; an edge is current=1 and previous=0. Previous registers reset to 1, so a button held through reset produces no edge.
- Priority each cycle, highest first: RST, !on_off → IDLE, reset_game edge → IDLE, then the per-state rules.
- IDLE: obj_rst=1, obj_run=0. A start_game edge → COUNTDOWN.
- COUNTDOWN: obj_rst=1. The frame counter counts frame_tick. countdown_digit = 3 − floor(count / CD_STEP_FRAMES). After 3·CD_STEP_FRAMES ticks → PLAY, and the counter clears.
- PLAY: obj_run=1, obj_rst=0.
  - score_pulse increments score, saturating at SCORE_MAX.
  - Each increment advances a points counter. On reaching SPEED_STEP_POINTS the points counter wraps to 0 and speed_level increments, saturating at MAX_LEVEL.
  - end_game=1 → OVER. A score_pulse in the same cycle is dropped.
- OVER: obj_run=0, obj_rst=0, which freezes the scene. The frame counter counts to OVER_HOLD_FRAMES.
  - Start edges before the hold completes are ignored.
  - After the hold, a start_game edge → COUNTDOWN.
- Entry to COUNTDOWN from any state: score_clr pulse; score, points counter and speed_level clear to 0.
- High score: on the PLAY→OVER transition, if score > high_score then high_score ← score. It is cleared only by RST, not by reset_game or on_off.
- Entry to IDLE clears score, speed_level and all counters.

## Timing
- Reset values: state=IDLE, obj_rst=1, obj_run=0, score_clr=0, countdown_digit=0, speed_level=0, score=0, high_score=0.
- All outputs are registered.
- Latency from input edge or level to state/outputs: one CLK.
- score updates one CLK after score_pulse.
- high_score is valid one CLK after entering OVER.
- countdown_digit becomes 3 in the same cycle state becomes COUNTDOWN.
- The COUNTDOWN→PLAY transition happens on the CLK after the terminal frame_tick.
- Simultaneous start_game and reset_game edges: reset wins, result is IDLE.
- on_off low mid-PLAY: IDLE on the next CLK; high_score is not updated.
- Score at SCORE_MAX: further pulses are ignored; speed_level still follows points-counter rules.

## Configuration
- PAUSE_EN:
  - Defined: adds input pause (1 bit, level, rising edge) and state encoding PAUSED; state widens to 3 bits, PAUSED=100.
  - A pause edge toggles PLAY↔PAUSED. In PAUSED, obj_run=0 and score_pulse and end_game are ignored.
  - reset_game and on_off keep priority over pause.
- Undefined: no pause port, 2-bit state, four states.

## Structure
- game_pkg holds the state encodings, SCORE_W=14, LEVEL_W=3, and the PAUSED encoding guarded by PAUSE_EN.
- Sub-module rise_edge is instantiated per button (two, three with PAUSE_EN); it holds the reset-to-1 previous register and a one-cycle pulse output.
- Frame counter and points counter are inline.

## Test plan
- RST, then start_game rising → COUNTDOWN next CLK; countdown_digit 3/2/1 across 180 frame_ticks (default); PLAY after tick 180; obj_run=1.
- In PLAY, 25 score_pulses → score=25, speed_level=2; 100 pulses → speed_level saturates at 7.
- end_game together with score_pulse at score=12 → OVER, score stays 12, high_score=12; a second game ending at 5 leaves high_score=12.
- In OVER, start edge at frame 50 is ignored; start edge at frame 121 → COUNTDOWN, score_clr pulse, score=0, high_score still 12.
- reset_game edge during PLAY, and on_off low during COUNTDOWN → IDLE next CLK, obj_rst=1; start held through RST produces no transition.
- With PAUSE_EN: pause edge in PLAY → PAUSED, score_pulse/end_game ignored; second pause edge → PLAY with score unchanged.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the two-car game controller: state encodings and
// datapath widths. Defining PAUSE_EN widens the state field to 3 bits and
// adds the PAUSED encoding.
package game_pkg;

`ifdef PAUSE_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    localparam int SCORE_W = 14;
    localparam int LEVEL_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = STATE_W'(2'b00);
    localparam logic [STATE_W-1:0] ST_COUNTDOWN = STATE_W'(2'b01);
    localparam logic [STATE_W-1:0] ST_PLAY      = STATE_W'(2'b10);
    localparam logic [STATE_W-1:0] ST_OVER      = STATE_W'(2'b11);
`ifdef PAUSE_EN
    localparam logic [STATE_W-1:0] ST_PAUSED    = 3'b100;
`endif

endpackage

// File: rtl/game_controller_rise_edge.sv
// Rising-edge detector for one debounced, CLK-synchronous button level.
// The previous-value register resets to 1, so a button that is already held
// when reset is released does not produce an edge.
module rise_edge (
    input  logic CLK,
    input  logic RST,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    // Remember last cycle's level; reset to 1 so a held button is not an edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Top-level sequencer for the two-car game: IDLE / COUNTDOWN / PLAY / OVER
// state machine, obstacle gating, score, speed level and high score.
// Optional build macro PAUSE_EN adds a pause input and the PAUSED state.
module game_controller
    import game_pkg::*;
#(
    parameter int CD_STEP_FRAMES    = 60,
    parameter int OVER_HOLD_FRAMES  = 120,
    parameter int SPEED_STEP_POINTS = 10,
    parameter int MAX_LEVEL         = 7,
    parameter int SCORE_MAX         = 9999
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               frame_tick,
    input  logic               on_off,
    input  logic               start_game,
    input  logic               reset_game,
`ifdef PAUSE_EN
    input  logic               pause,
`endif
    input  logic               end_game,
    input  logic               score_pulse,
    output logic [STATE_W-1:0] state,
    output logic               obj_run,
    output logic               obj_rst,
    output logic               score_clr,
    output logic [1:0]         countdown_digit,
    output logic [LEVEL_W-1:0] speed_level,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    // One frame counter serves both the per-digit countdown and the OVER hold
    localparam int FRAME_MAX = (OVER_HOLD_FRAMES > CD_STEP_FRAMES) ? OVER_HOLD_FRAMES : CD_STEP_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int PTS_W     = $clog2(SPEED_STEP_POINTS + 1);

    localparam logic [FRAME_W-1:0] CD_LAST   = FRAME_W'(CD_STEP_FRAMES - 1);
    localparam logic [FRAME_W-1:0] HOLD_DONE = FRAME_W'(OVER_HOLD_FRAMES);
    localparam logic [PTS_W-1:0]   PTS_LAST  = PTS_W'(SPEED_STEP_POINTS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

    logic [STATE_W-1:0] state_q, state_d;
    logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;
    logic [PTS_W-1:0]   pts_q, pts_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [1:0]         digit_q, digit_d;
    logic               scoreClr_q, scoreClr_d;
    logic               objRun_q, objRun_d;
    logic               objRst_q, objRst_d;
    logic               goCountdown;

    logic startEdge;
    logic resetEdge;

    rise_edge uStartEdge (
        .CLK     (CLK),
        .RST     (RST),
        .level_i (start_game),
        .pulse_o (startEdge)
    );

    rise_edge uResetEdge (
        .CLK     (CLK),
        .RST     (RST),
        .level_i (reset_game),
        .pulse_o (resetEdge)
    );

`ifdef PAUSE_EN
    logic pauseEdge;

    rise_edge uPauseEdge (
        .CLK     (CLK),
        .RST     (RST),
        .level_i (pause),
        .pulse_o (pauseEdge)
    );
`endif

    // Next-state and datapath update: power/reset-game first, then per-state rules
    always_comb begin
        state_d     = state_q;
        frameCnt_d  = frameCnt_q;
        pts_d       = pts_q;
        level_d     = level_q;
        score_d     = score_q;
        high_d      = high_q;
        digit_d     = 2'd0;
        scoreClr_d  = 1'b0;
        goCountdown = 1'b0;

        if (!on_off || resetEdge) begin
            state_d    = ST_IDLE;
            frameCnt_d = '0;
            pts_d      = '0;
            level_d    = '0;
            score_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startEdge) begin
                        goCountdown = 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    digit_d = digit_q;
                    if (frame_tick) begin
                        if (frameCnt_q == CD_LAST) begin
                            frameCnt_d = '0;
                            if (digit_q == 2'd1) begin
                                state_d = ST_PLAY;
                                digit_d = 2'd0;
                            end else begin
                                digit_d = digit_q - 2'd1;
                            end
                        end else begin
                            frameCnt_d = frameCnt_q + FRAME_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (end_game) begin
                        state_d    = ST_OVER;
                        frameCnt_d = '0;
                        if (score_q > high_q) begin
                            high_d = score_q;
                        end
                    end else begin
                        if (score_pulse) begin
                            if (score_q < SCORE_TOP) begin
                                score_d = score_q + SCORE_W'(1);
                            end
                            if (pts_q == PTS_LAST) begin
                                pts_d = '0;
                                if (level_q != LEVEL_TOP) begin
                                    level_d = level_q + LEVEL_W'(1);
                                end
                            end else begin
                                pts_d = pts_q + PTS_W'(1);
                            end
                        end
`ifdef PAUSE_EN
                        if (pauseEdge) begin
                            state_d = ST_PAUSED;
                        end
`endif
                    end
                end
                ST_OVER: begin
                    if (frameCnt_q < HOLD_DONE) begin
                        if (frame_tick) begin
                            frameCnt_d = frameCnt_q + FRAME_W'(1);
                        end
                    end else if (startEdge) begin
                        goCountdown = 1'b1;
                    end
                end
`ifdef PAUSE_EN
                ST_PAUSED: begin
                    if (pauseEdge) begin
                        state_d = ST_PLAY;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (goCountdown) begin
                state_d    = ST_COUNTDOWN;
                frameCnt_d = '0;
                pts_d      = '0;
                level_d    = '0;
                score_d    = '0;
                digit_d    = 2'd3;
                scoreClr_d = 1'b1;
            end
        end

        objRun_d = (state_d == ST_PLAY);
        objRst_d = (state_d == ST_IDLE) || (state_d == ST_COUNTDOWN);
    end

    // Register state, counters and every output so outputs are glitch-free
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            frameCnt_q <= '0;
            pts_q      <= '0;
            level_q    <= '0;
            score_q    <= '0;
            high_q     <= '0;
            digit_q    <= 2'd0;
            scoreClr_q <= 1'b0;
            objRun_q   <= 1'b0;
            objRst_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            frameCnt_q <= frameCnt_d;
            pts_q      <= pts_d;
            level_q    <= level_d;
            score_q    <= score_d;
            high_q     <= high_d;
            digit_q    <= digit_d;
            scoreClr_q <= scoreClr_d;
            objRun_q   <= objRun_d;
            objRst_q   <= objRst_d;
        end
    end

    assign state           = state_q;
    assign obj_run         = objRun_q;
    assign obj_rst         = objRst_q;
    assign score_clr       = scoreClr_q;
    assign countdown_digit = digit_q;
    assign speed_level     = level_q;
    assign score           = score_q;
    assign high_score      = high_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with default parameters
// (60 frames per countdown digit, 120-frame OVER hold, 10 points per level).
module tb_game_controller;
    import game_pkg::*;

    logic               CLK = 1'b0;
    logic               RST;
    logic               frame_tick;
    logic               on_off;
    logic               start_game;
    logic               reset_game;
    logic               end_game;
    logic               score_pulse;
`ifdef PAUSE_EN
    logic               pause;
`endif
    logic [STATE_W-1:0] state;
    logic               obj_run;
    logic               obj_rst;
    logic               score_clr;
    logic [1:0]         countdown_digit;
    logic [LEVEL_W-1:0] speed_level;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic               start;
        logic               resetG;
        logic               onOff;
        logic               tick;
        logic [STATE_W-1:0] expState;
        logic [1:0]         expDigit;
        logic               expClr;
        logic               expRun;
        logic               expRst;
    } vec_t;

    vec_t vecs[13];

    always #5 CLK = ~CLK;

    game_controller dut (
        .CLK             (CLK),
        .RST             (RST),
        .frame_tick      (frame_tick),
        .on_off          (on_off),
        .start_game      (start_game),
        .reset_game      (reset_game),
`ifdef PAUSE_EN
        .pause           (pause),
`endif
        .end_game        (end_game),
        .score_pulse     (score_pulse),
        .state           (state),
        .obj_run         (obj_run),
        .obj_rst         (obj_rst),
        .score_clr       (score_clr),
        .countdown_digit (countdown_digit),
        .speed_level     (speed_level),
        .score           (score),
        .high_score      (high_score)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rg, input logic on,
                                 input logic eg, input logic sp, input logic ft);
        start_game  = st;
        reset_game  = rg;
        on_off      = on;
        end_game    = eg;
        score_pulse = sp;
        frame_tick  = ft;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkMode(input string name, input logic [STATE_W-1:0] expState,
                             input logic expRun, input logic expRst);
        checkOutput({name, ".state"}, 32'(state), 32'(expState));
        checkOutput({name, ".obj_run"}, 32'(obj_run), 32'(expRun));
        checkOutput({name, ".obj_rst"}, 32'(obj_rst), 32'(expRst));
    endtask

    // 180 frame ticks, one idle cycle between ticks; digit checked when asked
    task automatic runCountdown(input bit checkDigits);
        for (int i = 1; i <= 180; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            if (checkDigits) begin
                if (i < 180) begin
                    checkOutput($sformatf("cd.digit@%0d", i), 32'(countdown_digit), 32'(3 - i / 60));
                    checkOutput($sformatf("cd.state@%0d", i), 32'(state), 32'(ST_COUNTDOWN));
                end
            end
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkMode("cd.end", ST_PLAY, 1'b1, 1'b0);
        checkOutput("cd.end.digit", 32'(countdown_digit), 32'd0);
    endtask

    task automatic scorePulses(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic overTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic startEdgeRelease();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Fields: start, resetG, onOff, tick, state, digit, score_clr, obj_run, obj_rst
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, ST_COUNTDOWN, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, ST_COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, ST_COUNTDOWN, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_COUNTDOWN, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, ST_COUNTDOWN, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,      2'd0, 1'b0, 1'b0, 1'b1};

`ifdef PAUSE_EN
        pause = 1'b0;
`endif
        // Reset with start_game held high the whole time
        RST         = 1'b1;
        start_game  = 1'b1;
        reset_game  = 1'b0;
        on_off      = 1'b1;
        end_game    = 1'b0;
        score_pulse = 1'b0;
        frame_tick  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkMode("reset", ST_IDLE, 1'b0, 1'b1);
        checkOutput("reset.score_clr", 32'(score_clr), 32'd0);
        checkOutput("reset.digit", 32'(countdown_digit), 32'd0);
        checkOutput("reset.speed", 32'(speed_level), 32'd0);
        checkOutput("reset.score", 32'(score), 32'd0);
        checkOutput("reset.high", 32'(high_score), 32'd0);

        // Table: held start, start edges, on_off drop, simultaneous start/reset edges
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].start, vecs[v].resetG, vecs[v].onOff, 1'b0, 1'b0, vecs[v].tick);
            checkMode($sformatf("vec%0d", v), vecs[v].expState, vecs[v].expRun, vecs[v].expRst);
            checkOutput($sformatf("vec%0d.digit", v), 32'(countdown_digit), 32'(vecs[v].expDigit));
            checkOutput($sformatf("vec%0d.score_clr", v), 32'(score_clr), 32'(vecs[v].expClr));
        end

        // Game 1: full countdown, 12 points, end_game with a simultaneous point
        startEdgeRelease();
        checkOutput("g1.start.state", 32'(state), 32'(ST_COUNTDOWN));
        runCountdown(1'b1);
        for (int i = 1; i <= 12; i++) begin
            scorePulses(1);
            checkOutput($sformatf("g1.score@%0d", i), 32'(score), 32'(i));
        end
        checkOutput("g1.speed", 32'(speed_level), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkMode("g1.over", ST_OVER, 1'b0, 1'b0);
        checkOutput("g1.over.score", 32'(score), 32'd12);
        checkOutput("g1.over.high", 32'(high_score), 32'd12);

        // OVER hold: edges at frame 50 and 119 ignored, edge at frame 121 accepted
        overTicks(50);
        startEdgeRelease();
        checkOutput("hold50.state", 32'(state), 32'(ST_OVER));
        overTicks(69);
        startEdgeRelease();
        checkOutput("hold119.state", 32'(state), 32'(ST_OVER));
        overTicks(2);
        startEdgeRelease();
        checkMode("hold121", ST_COUNTDOWN, 1'b0, 1'b1);
        checkOutput("hold121.score_clr", 32'(score_clr), 32'd1);
        checkOutput("hold121.score", 32'(score), 32'd0);
        checkOutput("hold121.digit", 32'(countdown_digit), 32'd3);
        checkOutput("hold121.high", 32'(high_score), 32'd12);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hold121.clr_drop", 32'(score_clr), 32'd0);

        // Game 2: ends at 5, high score keeps 12
        runCountdown(1'b0);
        scorePulses(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("g2.over.state", 32'(state), 32'(ST_OVER));
        checkOutput("g2.over.score", 32'(score), 32'd5);
        checkOutput("g2.over.high", 32'(high_score), 32'd12);

        // Game 3: speed levels, saturation at 7, then reset_game edge during PLAY
        overTicks(121);
        startEdgeRelease();
        runCountdown(1'b0);
        scorePulses(25);
        checkOutput("g3.score25", 32'(score), 32'd25);
        checkOutput("g3.speed25", 32'(speed_level), 32'd2);
        scorePulses(44);
        checkOutput("g3.speed69", 32'(speed_level), 32'd6);
        scorePulses(1);
        checkOutput("g3.speed70", 32'(speed_level), 32'd7);
        scorePulses(30);
        checkOutput("g3.score100", 32'(score), 32'd100);
        checkOutput("g3.speed100", 32'(speed_level), 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkMode("g3.reset", ST_IDLE, 1'b0, 1'b1);
        checkOutput("g3.reset.score", 32'(score), 32'd0);
        checkOutput("g3.reset.speed", 32'(speed_level), 32'd0);
        checkOutput("g3.reset.high", 32'(high_score), 32'd12);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // on_off low during COUNTDOWN
        startEdgeRelease();
        overTicks(10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkMode("onoff.cd", ST_IDLE, 1'b0, 1'b1);
        checkOutput("onoff.cd.digit", 32'(countdown_digit), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Game 4: score saturates at 9999, then on_off drop leaves high score alone
        startEdgeRelease();
        runCountdown(1'b0);
        scorePulses(9999);
        checkOutput("g4.score9999", 32'(score), 32'd9999);
        scorePulses(1);
        checkOutput("g4.score_sat", 32'(score), 32'd9999);
        checkOutput("g4.speed_sat", 32'(speed_level), 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkMode("g4.onoff", ST_IDLE, 1'b0, 1'b1);
        checkOutput("g4.onoff.high", 32'(high_score), 32'd12);
        checkOutput("g4.onoff.score", 32'(score), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
